// File: rtl/chain_code_pkg.sv
// Shared constants for the Freeman chain-code decoder: direction codes, FSM states,
// error-flag bit positions and the direction-to-offset lookups.
package chain_code_pkg;

  localparam logic [2:0] DIR_E  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_N  = 3'd2;
  localparam logic [2:0] DIR_NW = 3'd3;
  localparam logic [2:0] DIR_W  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_S  = 3'd6;
  localparam logic [2:0] DIR_SE = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int ERR_OPEN  = 0;
  localparam int ERR_PERIM = 1;
  localparam int ERR_AREA  = 2;
  localparam int ERR_OOB   = 3;

  // y grows downwards (row index), so "north" codes decrement y
  function automatic logic signed [1:0] dir_dx(input logic [2:0] c);
    case (c)
      DIR_E, DIR_NE, DIR_SE: dir_dx = 2'sd1;
      DIR_NW, DIR_W, DIR_SW: dir_dx = -2'sd1;
      default:               dir_dx = 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [2:0] c);
    case (c)
      DIR_NE, DIR_N, DIR_NW: dir_dy = -2'sd1;
      DIR_SW, DIR_S, DIR_SE: dir_dy = 2'sd1;
      default:               dir_dy = 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/chain_code_step.sv
// Registered contour position with next-step bounds check, wrap and shoelace term.
// Next-pixel outputs exist only when PIXEL_WR_EN is defined.
module chain_code_step
  import chain_code_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int XW    = 6,
  parameter int YW    = 6,
  parameter int TW    = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [XW-1:0]        i_ld_x,
  input  logic [YW-1:0]        i_ld_y,
  input  logic                 i_step,
  input  logic [2:0]           i_code,
  output logic [XW-1:0]        o_x,
  output logic [YW-1:0]        o_y,
`ifdef PIXEL_WR_EN
  output logic [XW-1:0]        o_nx,
  output logic [YW-1:0]        o_ny,
`endif
  output logic                 o_oob,
  output logic signed [TW-1:0] o_term
);

  localparam logic signed [XW+1:0] X_MAX  = (XW+2)'(IMG_W-1);
  localparam logic signed [YW+1:0] Y_MAX  = (YW+2)'(IMG_H-1);
  localparam logic [XW-1:0]        X_LAST = XW'(IMG_W-1);
  localparam logic [YW-1:0]        Y_LAST = YW'(IMG_H-1);

  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic signed [1:0]    w_dx, w_dy;
  logic signed [XW+1:0] w_sx;
  logic signed [YW+1:0] w_sy;
  logic                 w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic [XW-1:0]        w_nx;
  logic [YW-1:0]        w_ny;
  logic signed [TW-1:0] w_xs, w_ys, w_tx, w_ty;

  assign w_dx = dir_dx(i_code);
  assign w_dy = dir_dy(i_code);
  assign w_sx = $signed({2'b00, r_x}) + $signed({{XW{w_dx[1]}}, w_dx});
  assign w_sy = $signed({2'b00, r_y}) + $signed({{YW{w_dy[1]}}, w_dy});

  assign w_x_lo = w_sx[XW+1];
  assign w_x_hi = (w_sx > X_MAX);
  assign w_y_lo = w_sy[YW+1];
  assign w_y_hi = (w_sy > Y_MAX);

  // leaving the frame wraps to the opposite edge; the walk carries on
  assign w_nx = w_x_lo ? X_LAST : (w_x_hi ? '0 : w_sx[XW-1:0]);
  assign w_ny = w_y_lo ? Y_LAST : (w_y_hi ? '0 : w_sy[YW-1:0]);

  assign w_xs = $signed({{(TW-XW){1'b0}}, r_x});
  assign w_ys = $signed({{(TW-YW){1'b0}}, r_y});
  assign w_tx = (w_dy == 2'sd1) ? w_xs : ((w_dy == -2'sd1) ? -w_xs : '0);
  assign w_ty = (w_dx == 2'sd1) ? w_ys : ((w_dx == -2'sd1) ? -w_ys : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= i_ld_x;
      r_y <= i_ld_y;
    end else if (i_step) begin
      r_x <= w_nx;
      r_y <= w_ny;
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_oob  = w_x_lo | w_x_hi | w_y_lo | w_y_hi;
  assign o_term = w_tx - w_ty;
`ifdef PIXEL_WR_EN
  assign o_nx   = w_nx;
  assign o_ny   = w_ny;
`endif

endmodule

// File: rtl/chain_code_decoder_p.sv
// Freeman chain-code decoder: walks a contour, accumulates 2x shoelace area and checks
// closure/perimeter/area/bounds. Define PIXEL_WR_EN to add the frame-buffer pixel write port.
module chain_code_decoder_p
  import chain_code_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int XW     = $clog2(IMG_W),
  parameter int YW     = $clog2(IMG_H),
  parameter int LEN_W  = 9,
  parameter int AREA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [XW-1:0]     i_start_x,
  input  logic [YW-1:0]     i_start_y,
  input  logic [LEN_W-1:0]  i_exp_perimeter,
  input  logic [AREA_W-1:0] i_exp_area,
  input  logic [2:0]        i_code,
  input  logic              i_code_valid,
  input  logic              i_code_last,
  output logic              o_code_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
`ifdef PIXEL_WR_EN
  output logic              o_pix_we,
  output logic [XW-1:0]     o_pix_x,
  output logic [YW-1:0]     o_pix_y,
`endif
  output logic [3:0]        o_err_flags
);

  localparam int A2W = AREA_W + 2;

  logic [1:0]            r_state;
  logic [XW-1:0]         r_sx;
  logic [YW-1:0]         r_sy;
  logic [LEN_W-1:0]      r_exp_perim;
  logic [AREA_W-1:0]     r_exp_area;
  logic [LEN_W-1:0]      r_cnt;
  logic signed [A2W-1:0] r_a2;
  logic                  r_last;
  logic [3:0]            r_err;

  logic                  w_accept_start, w_hs, w_end, w_oob;
  logic [LEN_W-1:0]      w_cnt_inc;
  logic [XW-1:0]         w_x;
  logic [YW-1:0]         w_y;
  logic signed [A2W-1:0] w_term;
  logic [A2W-1:0]        w_abs, w_half;
`ifdef PIXEL_WR_EN
  logic [XW-1:0]         w_nx;
  logic [YW-1:0]         w_ny;
`endif

  assign w_accept_start = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_hs      = i_code_valid & (r_state == ST_RUN);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_end     = w_hs & (i_code_last | (w_cnt_inc == r_exp_perim));
  assign w_abs     = r_a2[A2W-1] ? $unsigned(-r_a2) : $unsigned(r_a2);
  assign w_half    = w_abs >> 1;

  chain_code_step #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW), .TW(A2W)
  ) u_step (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept_start),
    .i_ld_x (i_start_x),
    .i_ld_y (i_start_y),
    .i_step (w_hs),
    .i_code (i_code),
    .o_x    (w_x),
    .o_y    (w_y),
`ifdef PIXEL_WR_EN
    .o_nx   (w_nx),
    .o_ny   (w_ny),
`endif
    .o_oob  (w_oob),
    .o_term (w_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sx        <= '0;
      r_sy        <= '0;
      r_exp_perim <= '0;
      r_exp_area  <= '0;
      r_cnt       <= '0;
      r_a2        <= '0;
      r_last      <= 1'b0;
      r_err       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept_start) begin
            r_sx        <= i_start_x;
            r_sy        <= i_start_y;
            r_exp_perim <= i_exp_perimeter;
            r_exp_area  <= i_exp_area;
            r_cnt       <= '0;
            r_a2        <= '0;
            r_err       <= '0;
            // an empty contour is trivially consistent, so treat it as already "last"
            r_last      <= (i_exp_perimeter == '0);
            r_state     <= (i_exp_perimeter == '0) ? ST_CHECK : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            r_cnt <= w_cnt_inc;
            r_a2  <= r_a2 + w_term;
            if (w_oob) r_err[ERR_OOB] <= 1'b1;
            if (w_end) begin
              r_last  <= i_code_last;
              r_state <= ST_CHECK;
            end
          end
        end
        default: begin
          r_err[ERR_OPEN]  <= (w_x != r_sx) | (w_y != r_sy);
          r_err[ERR_PERIM] <= (r_cnt != r_exp_perim) | ~r_last;
          r_err[ERR_AREA]  <= (w_half != {2'b00, r_exp_area});
          r_state          <= ST_DONE;
        end
      endcase
    end
  end

`ifdef PIXEL_WR_EN
  logic          r_pix_we;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_we <= 1'b0;
      r_pix_x  <= '0;
      r_pix_y  <= '0;
    end else begin
      r_pix_we <= 1'b0;
      if (w_accept_start && (i_exp_perimeter != '0)) begin
        r_pix_we <= 1'b1;
        r_pix_x  <= i_start_x;
        r_pix_y  <= i_start_y;
      end else if (w_hs) begin
        r_pix_we <= ~w_oob;
        r_pix_x  <= w_nx;
        r_pix_y  <= w_ny;
      end
    end
  end

  assign o_pix_we = r_pix_we;
  assign o_pix_x  = r_pix_x;
  assign o_pix_y  = r_pix_y;
`endif

  assign o_code_ready = (r_state == ST_RUN);
  assign o_busy       = (r_state == ST_RUN) | (r_state == ST_CHECK);
  assign o_done       = (r_state == ST_DONE);
  assign o_error      = o_done & (|r_err);
  assign o_err_flags  = r_err;

endmodule

// File: tb/tb_chain_code_decoder_p.sv
// Directed bench for chain_code_decoder_p; define PIXEL_WR_EN to also check the pixel port.
module tb_chain_code_decoder_p;

  localparam int XW = 6;
  localparam int YW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [XW-1:0] i_start_x = '0;
  logic [YW-1:0] i_start_y = '0;
  logic [8:0]    i_exp_perimeter = '0;
  logic [11:0]   i_exp_area = '0;
  logic [2:0]    i_code = '0;
  logic          i_code_valid = 1'b0;
  logic          i_code_last = 1'b0;
  logic          o_code_ready, o_busy, o_done, o_error;
  logic [3:0]    o_err_flags;
`ifdef PIXEL_WR_EN
  logic          o_pix_we;
  logic [XW-1:0] o_pix_x;
  logic [YW-1:0] o_pix_y;
  logic [11:0]   pix_q[$];
`endif

  int n_assert = 0;
  int n_fail   = 0;

  chain_code_decoder_p dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_start_x       (i_start_x),
    .i_start_y       (i_start_y),
    .i_exp_perimeter (i_exp_perimeter),
    .i_exp_area      (i_exp_area),
    .i_code          (i_code),
    .i_code_valid    (i_code_valid),
    .i_code_last     (i_code_last),
    .o_code_ready    (o_code_ready),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_error         (o_error),
`ifdef PIXEL_WR_EN
    .o_pix_we        (o_pix_we),
    .o_pix_x         (o_pix_x),
    .o_pix_y         (o_pix_y),
`endif
    .o_err_flags     (o_err_flags)
  );

  always #5 clk = ~clk;

`ifdef PIXEL_WR_EN
  always @(negedge clk) if (o_pix_we) pix_q.push_back({o_pix_x, o_pix_y});
`endif

  task automatic chk(input string tag, input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s %s: observed %0h expected %0h", tag, what, got, exp);
    end
  endtask

  // codes packed 3 bits each, first code in bits [2:0]; last_idx<0 means no code_last
  task automatic run(input string tag, input logic [5:0] sx, input logic [5:0] sy,
                     input logic [8:0] perim, input logic [11:0] area,
                     input logic [23:0] codes, input int n, input int last_idx,
                     input bit gaps, input bit poke, input logic [3:0] exp_flags);
    i_start_x = sx; i_start_y = sy; i_exp_perimeter = perim; i_exp_area = area;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    if (perim != 0) chk(tag, "ready_after_start", 32'(o_code_ready), 32'd1);
    chk(tag, "busy_after_start", 32'(o_busy), 32'd1);
    chk(tag, "done_cleared", 32'(o_done), 32'd0);
    chk(tag, "flags_cleared", 32'(o_err_flags), 32'd0);
    if (poke) begin
      i_start = 1'b1; i_start_x = 6'd0; i_start_y = 6'd0;
      i_exp_perimeter = 9'd7; i_exp_area = 12'd9;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk(tag, "start_ignored_in_run", 32'(o_code_ready), 32'd1);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      i_code = codes[3*i +: 3];
      i_code_valid = 1'b1;
      i_code_last = (i == last_idx);
      chk(tag, "ready_before_code", 32'(o_code_ready), 32'd1);
      @(posedge clk); #1;
      i_code_valid = 1'b0;
      i_code_last = 1'b0;
    end
    chk(tag, "busy_in_check", 32'(o_busy), 32'd1);
    chk(tag, "done_latency", 32'(o_done), 32'd0);
    @(posedge clk); #1;
    chk(tag, "done", 32'(o_done), 32'd1);
    chk(tag, "err_flags", 32'(o_err_flags), 32'(exp_flags));
    chk(tag, "error", 32'(o_error), 32'(|exp_flags));
    chk(tag, "busy_done", 32'(o_busy), 32'd0);
    chk(tag, "ready_done", 32'(o_code_ready), 32'd0);
  endtask

  localparam logic [23:0] SQUARE = {12'd0, 3'd2, 3'd4, 3'd6, 3'd0};

  initial begin
    #12;
    chk("reset", "ready", 32'(o_code_ready), 32'd0);
    chk("reset", "busy", 32'(o_busy), 32'd0);
    chk("reset", "done", 32'(o_done), 32'd0);
    chk("reset", "error", 32'(o_error), 32'd0);
    chk("reset", "err_flags", 32'(o_err_flags), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // code_valid while idle must not be accepted
    i_code_valid = 1'b1; i_code = 3'd0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_valid", "ready", 32'(o_code_ready), 32'd0);
    chk("idle_valid", "busy", 32'(o_busy), 32'd0);
    i_code_valid = 1'b0;

`ifdef PIXEL_WR_EN
    pix_q.delete();
`endif
    run("t1_square", 6'd10, 6'd10, 9'd4, 12'd1, SQUARE, 4, 3, 1'b0, 1'b0, 4'b0000);
`ifdef PIXEL_WR_EN
    begin
      logic [11:0] exp_pix [5];
      exp_pix[0] = {6'd10, 6'd10}; exp_pix[1] = {6'd11, 6'd10};
      exp_pix[2] = {6'd11, 6'd11}; exp_pix[3] = {6'd10, 6'd11};
      exp_pix[4] = {6'd10, 6'd10};
      chk("t6_pix", "count", 32'(pix_q.size()), 32'd5);
      for (int i = 0; i < 5; i++)
        if (i < pix_q.size()) chk("t6_pix", $sformatf("pix%0d", i), 32'(pix_q[i]), 32'(exp_pix[i]));
    end
`endif
    run("t2_open", 6'd10, 6'd10, 9'd3, 12'd4, {15'd0, 3'd6, 3'd0, 3'd0}, 3, 2, 1'b0, 1'b0, 4'b0001);
    run("t3_early_last", 6'd10, 6'd10, 9'd4, 12'd6, {15'd0, 3'd4, 3'd6, 3'd0}, 3, 2, 1'b0, 1'b0, 4'b0011);
    run("t4_oob", 6'd0, 6'd5, 9'd2, 12'd0, {18'd0, 3'd0, 3'd4}, 2, 1, 1'b0, 1'b0, 4'b1000);
    run("count_end", 6'd10, 6'd10, 9'd2, 12'd0, {18'd0, 3'd4, 3'd0}, 2, -1, 1'b0, 1'b1, 4'b0010);
    run("zero_perim", 6'd20, 6'd30, 9'd0, 12'd0, 24'd0, 0, -1, 1'b0, 1'b0, 4'b0000);
    run("t5_gaps", 6'd10, 6'd10, 9'd4, 12'd1, SQUARE, 4, 3, 1'b1, 1'b0, 4'b0000);

    // abandon a contour half-way with an asynchronous reset
    i_start_x = 6'd10; i_start_y = 6'd10; i_exp_perimeter = 9'd4; i_exp_area = 12'd1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_code_valid = 1'b1; i_code = 3'd0;
    @(posedge clk); #1;
    i_code = 3'd6;
    @(posedge clk); #2;
    i_code_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_reset", "ready", 32'(o_code_ready), 32'd0);
    chk("t5_reset", "busy", 32'(o_busy), 32'd0);
    chk("t5_reset", "done", 32'(o_done), 32'd0);
    chk("t5_reset", "error", 32'(o_error), 32'd0);
    chk("t5_reset", "err_flags", 32'(o_err_flags), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run("t5_rerun", 6'd10, 6'd10, 9'd4, 12'd1, SQUARE, 4, 3, 1'b1, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
